// File: rtl/conway_gen_ctrl.sv
// Host command sequencer for the Life engine: clear/set/run/stop strobes, generation count, watchdog.
// Registered outputs one cycle after accept; cmd_ready drops while clearing, writing or draining a stop.
module conway_gen_ctrl #(
    parameter int GEN_W      = 16,
    parameter int TIMEOUT    = 8192,
    parameter int CLR_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [15:0]      i_cmd_addr,
    input  logic [GEN_W-1:0] i_cmd_count,
    output logic             o_eng_clr,
    output logic             o_eng_wr,
    output logic [15:0]      o_eng_addr,
    output logic             o_eng_run,
    input  logic             i_eng_next_gen,
    output logic             o_busy,
    output logic [GEN_W-1:0] o_gen_count,
    output logic             o_done,
    output logic             o_cmd_err,
    output logic             o_timeout
);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_RUN   = 3'd3;
    localparam logic [2:0] OP_STOP  = 3'd4;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int CL_W = $clog2(CLR_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CL_W-1:0] CLR_LAST = CL_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_WR, ST_RUN, ST_STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_eng_clr, w_clr_nxt;
    logic             r_eng_wr, w_wr_nxt;
    logic [15:0]      r_eng_addr, w_addr_nxt;
    logic             r_eng_run, w_run_nxt;
    logic             r_done, w_done_nxt;
    logic             r_cmd_err, w_err_nxt;
    logic             r_timeout, w_to_nxt;
    logic [GEN_W-1:0] r_gen_count, w_gen_nxt;
    logic [GEN_W-1:0] r_remaining, w_rem_nxt;
    logic [WD_W-1:0]  r_wdog, w_wd_nxt;
    logic [CL_W-1:0]  r_clr_cnt, w_clrc_nxt;
    logic             w_acc;
    logic             w_stop_req;

    assign o_cmd_ready = (r_state == ST_IDLE) | (r_state == ST_RUN);
    assign w_acc       = i_cmd_valid & o_cmd_ready;
    // A stop already pending, or one arriving now, ends the run on the next boundary.
    assign w_stop_req  = (r_state == ST_STOP) | (w_acc & (i_cmd_op == OP_STOP));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_eng_clr   <= 1'b0;
            r_eng_wr    <= 1'b0;
            r_eng_addr  <= '0;
            r_eng_run   <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_gen_count <= '0;
            r_remaining <= '0;
            r_wdog      <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_clr   <= w_clr_nxt;
            r_eng_wr    <= w_wr_nxt;
            r_eng_addr  <= w_addr_nxt;
            r_eng_run   <= w_run_nxt;
            r_done      <= w_done_nxt;
            r_cmd_err   <= w_err_nxt;
            r_timeout   <= w_to_nxt;
            r_gen_count <= w_gen_nxt;
            r_remaining <= w_rem_nxt;
            r_wdog      <= w_wd_nxt;
            r_clr_cnt   <= w_clrc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_eng_clr;
        w_wr_nxt    = 1'b0;
        w_addr_nxt  = r_eng_addr;
        w_run_nxt   = r_eng_run;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_to_nxt    = r_timeout;
        w_gen_nxt   = r_gen_count;
        w_rem_nxt   = r_remaining;
        w_wd_nxt    = r_wdog;
        w_clrc_nxt  = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    case (i_cmd_op)
                        OP_NOP, OP_STOP: ;
                        OP_CLEAR: begin
                            w_state_nxt = ST_CLR;
                            w_clr_nxt   = 1'b1;
                            w_clrc_nxt  = '0;
                            w_gen_nxt   = '0;
                            w_to_nxt    = 1'b0;
                        end
                        OP_SET: begin
                            w_state_nxt = ST_WR;
                            w_wr_nxt    = 1'b1;
                            w_addr_nxt  = i_cmd_addr;
                        end
                        OP_RUN: begin
                            w_state_nxt = ST_RUN;
                            w_run_nxt   = 1'b1;
                            w_rem_nxt   = i_cmd_count;
                            w_wd_nxt    = '0;
                        end
                        default: w_err_nxt = 1'b1;
                    endcase
                end
            end
            ST_CLR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_clr_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clrc_nxt = r_clr_cnt + CL_W'(1);
                end
            end
            ST_WR: w_state_nxt = ST_IDLE;
            ST_RUN, ST_STOP: begin
                if (w_acc && (i_cmd_op != OP_STOP)) w_err_nxt = 1'b1;
                if (i_eng_next_gen) begin
                    w_gen_nxt = r_gen_count + GEN_W'(1);
                    w_wd_nxt  = '0;
                    if (r_remaining != '0) w_rem_nxt = r_remaining - GEN_W'(1);
                    if (w_stop_req || (r_remaining == GEN_W'(1))) begin
                        w_run_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_run_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_nxt = r_wdog + WD_W'(1);
                    if (w_stop_req) w_state_nxt = ST_STOP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_eng_clr   = r_eng_clr;
    assign o_eng_wr    = r_eng_wr;
    assign o_eng_addr  = r_eng_addr;
    assign o_eng_run   = r_eng_run;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_gen_count = r_gen_count;
    assign o_done      = r_done;
    assign o_cmd_err   = r_cmd_err;
    assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_conway_gen_ctrl.sv
// Bench for conway_gen_ctrl: directed scenarios plus random commands, each cycle compared
// against a timestamp-based behavioural model of the command contract.
module tb_conway_gen_ctrl;
    localparam int TIMEOUT = 8192;
    localparam int GEN_P   = 4096;
    localparam int CLR_N   = 2;

    localparam logic [2:0] OP_NOP = 3'd0, OP_CLEAR = 3'd1, OP_SET = 3'd2, OP_RUN = 3'd3, OP_STOP = 3'd4;
    localparam int M_IDLE = 0, M_CLR = 1, M_WR = 2, M_RUN = 3, M_STOP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_count = '0;
    logic        eng_next_gen = 1'b0;
    logic        cmd_ready, eng_clr, eng_wr, eng_run, busy, done, cmd_err, timeout_flag;
    logic [15:0] eng_addr, gen_count;

    always #5 clk = ~clk;

    conway_gen_ctrl #(.GEN_W(16), .TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_count(cmd_count),
        .o_eng_clr(eng_clr), .o_eng_wr(eng_wr), .o_eng_addr(eng_addr), .o_eng_run(eng_run),
        .i_eng_next_gen(eng_next_gen), .o_busy(busy), .o_gen_count(gen_count),
        .o_done(done), .o_cmd_err(cmd_err), .o_timeout(timeout_flag)
    );

    int n_cmp = 0, n_bad = 0;
    int n_done = 0, n_wr = 0, n_run = 0, n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: mode per command contract, watchdog as elapsed time since last event.
    int          cyc, m_mode, m_clr_left, m_left, m_ref, e_gen;
    bit          e_clr, e_wr, e_run, e_done, e_err, e_to;
    logic [15:0] e_addr;

    function automatic logic [63:0] dut_vec();
        return {24'b0, cmd_ready, busy, eng_clr, eng_wr, eng_run, done, cmd_err, timeout_flag, eng_addr, gen_count};
    endfunction

    function automatic logic [63:0] model_vec();
        logic m_rdy;
        m_rdy = (m_mode == M_IDLE) || (m_mode == M_RUN);
        return {24'b0, m_rdy, m_mode != M_IDLE, e_clr, e_wr, e_run, e_done, e_err, e_to, e_addr, e_gen[15:0]};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_clr_left = 0; m_left = 0; m_ref = 0; e_gen = 0;
        e_clr = 0; e_wr = 0; e_run = 0; e_done = 0; e_err = 0; e_to = 0; e_addr = '0;
    endtask

    task automatic model_step(input bit v, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] n, input bit ng);
        bit acc, stop_now, fin;
        acc = v && ((m_mode == M_IDLE) || (m_mode == M_RUN));
        e_wr = 0; e_done = 0; e_err = 0;
        if (m_mode == M_IDLE) begin
            if (acc) begin
                if (op == OP_CLEAR) begin
                    m_mode = M_CLR; m_clr_left = CLR_N; e_clr = 1; e_gen = 0; e_to = 0;
                end else if (op == OP_SET) begin
                    m_mode = M_WR; e_wr = 1; e_addr = a;
                end else if (op == OP_RUN) begin
                    m_mode = M_RUN; e_run = 1; m_left = int'(n); m_ref = cyc + 1;
                end else if (op > OP_STOP) begin
                    e_err = 1;
                end
            end
        end else if (m_mode == M_CLR) begin
            m_clr_left--;
            if (m_clr_left == 0) begin e_clr = 0; m_mode = M_IDLE; end
        end else if (m_mode == M_WR) begin
            m_mode = M_IDLE;
        end else begin
            stop_now = (m_mode == M_STOP) || (acc && op == OP_STOP);
            if (acc && op != OP_STOP) e_err = 1;
            if (ng) begin
                e_gen = (e_gen + 1) % 65536;
                m_ref = cyc + 1;
                fin = stop_now || (m_left == 1);
                if (m_left != 0) m_left--;
                if (fin) begin e_run = 0; e_done = 1; m_mode = M_IDLE; end
            end else if (cyc - m_ref + 1 >= TIMEOUT) begin
                e_run = 0; e_to = 1; m_mode = M_IDLE;
            end else if (stop_now) begin
                m_mode = M_STOP;
            end
        end
    endtask

    task automatic tick(input bit v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] n, input bit ng);
        cmd_valid = v; cmd_op = op; cmd_addr = a; cmd_count = n; eng_next_gen = ng;
        model_step(v, op, a, n, ng);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk_eq("outs", dut_vec(), model_vec());
        if (done) n_done++;
        if (eng_wr) n_wr++;
        if (eng_run) n_run++;
        if (cmd_err) n_err++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(0, OP_NOP, '0, '0, 0);
    endtask

    task automatic run_seq(input logic [15:0] cnt, input int stop_at, input int period, input int total);
        n_done = 0; n_run = 0;
        tick(1, OP_RUN, '0, cnt, 0);
        for (int k = 1; k <= total; k++)
            tick(k == stop_at, OP_STOP, '0, '0, (period != 0) && (k % period == 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_eq("arst", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        @(negedge clk);
        chk_eq("rst_ready", cmd_ready, 1);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_gen", gen_count, 0);
        chk_eq("rst_strobes", {eng_clr, eng_wr, eng_run, done, cmd_err, timeout_flag}, 0);
        rst_n = 1'b1;
        idle(2);

        n_wr = 0;
        tick(1, OP_SET, 16'h0A05, '0, 0);
        chk_eq("wr_lat", eng_wr, 1);
        chk_eq("wr_addr", eng_addr, 16'h0A05);
        idle(3);
        chk_eq("wr_once", n_wr, 1);
        chk_eq("wr_addr_hold", eng_addr, 16'h0A05);

        tick(1, OP_CLEAR, '0, '0, 0);
        idle(3);
        run_seq(16'd3, 0, GEN_P, 3 * GEN_P);
        chk_eq("run3_drop", {eng_run, done}, 2'b01);
        idle(3);
        chk_eq("run3_gen", gen_count, 3);
        chk_eq("run3_done", n_done, 1);
        chk_eq("run3_len", n_run, 3 * GEN_P);

        tick(1, OP_CLEAR, '0, '0, 0);
        idle(3);
        run_seq(16'd0, 6000, GEN_P, 2 * GEN_P);
        chk_eq("stop_end", {eng_run, done, busy}, 3'b010);
        chk_eq("stop_gen", gen_count, 2);
        chk_eq("stop_len", n_run, 2 * GEN_P);

        run_seq(16'd2, 0, 0, TIMEOUT);
        chk_eq("wd_flag", {timeout_flag, eng_run, busy}, 3'b100);
        idle(3);
        chk_eq("wd_nodone", n_done, 0);
        chk_eq("wd_len", n_run, TIMEOUT);
        chk_eq("wd_sticky", timeout_flag, 1);
        tick(1, OP_CLEAR, '0, '0, 0);
        chk_eq("clr_wd", {timeout_flag, gen_count}, 17'h0);
        idle(3);

        run_seq(16'd1, 10, 10, 10);
        idle(5);
        chk_eq("coinc_done", n_done, 1);
        chk_eq("coinc_idle", {busy, gen_count}, 17'h1);

        n_err = 0; n_wr = 0;
        tick(1, OP_RUN, '0, 16'd0, 0);
        tick(1, OP_SET, 16'h1234, '0, 0);
        chk_eq("run_set_err", cmd_err, 1);
        idle(3);
        tick(1, OP_STOP, '0, '0, 0);
        tick(0, OP_NOP, '0, '0, 1);
        idle(2);
        chk_eq("run_set_nowr", n_wr, 0);
        chk_eq("run_set_errcnt", n_err, 1);
        chk_eq("run_set_addr", eng_addr, 16'h0A05);

        for (int i = 0; i < 20000; i++) begin
            if (i == 10000) do_reset();
            tick($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 16'($urandom),
                 16'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
